// File: rtl/ccg_vector_sequencer.sv
// ccg_vector_sequencer
// Drives a 7-input combinational CUT with an exhaustive or LFSR vector
// stream and compacts its 4 outputs into a 16-bit MISR signature.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run request, sampled in IDLE and DONE only
//   mode       0 = exhaustive counter, 1 = 7-bit LFSR (latched with start)
//   x[6:0]     registered CUT input vector
//   f[3:0]     CUT outputs, combinational from x
//   busy       high while vectors are being applied
//   done       high once the run has finished
//   signature  MISR contents
//   vec_count  vectors compacted in the current or last run
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | one vector applied and compacted per cycle
// DONE  | run complete, results held, start restarts

module ccg_vector_sequencer #(
   parameter int unsigned N_VECT    = 128,
   parameter logic [6:0]  LFSR_SEED = 7'h01,
   parameter logic [15:0] MISR_SEED = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode,
   output logic [6:0]  x,
   input  logic [3:0]  f,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [15:0] vec_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [15:0] LAST_CNT  = 16'(N_VECT - 1);
   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [6:0]  LFSR_INIT = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
   // MISR feedback taps: s[15], s[13], s[12], s[10].
   localparam logic [15:0] MISR_TAPS = 16'hB400;

   state_t      state_q, state_d;
   logic [6:0]  x_q, x_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] sig_q, sig_d;
   logic [15:0] cnt_q, cnt_d;
   logic        mode_q, mode_d;
   logic        misr_fb;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      busy_d  = busy_q;
      done_d  = done_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      misr_fb = ^(sig_q & MISR_TAPS);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               mode_d  = mode;
               x_d     = mode ? LFSR_INIT : 7'h00;
               sig_d   = MISR_SEED;
               cnt_d   = 16'h0000;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            // The vector currently on x is compacted at this edge.
            sig_d = {sig_q[14:0], misr_fb} ^ {12'h000, f};
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (mode_q) begin
               x_d = {x_q[5:0], x_q[6] ^ x_q[5]};
            end else begin
               x_d = x_q + 7'd1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= 7'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sig_q   <= 16'h0000;
         cnt_q   <= 16'h0000;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign x         = x_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign signature = sig_q;
   assign vec_count = cnt_q;

endmodule

// File: tb/tb_ccg_vector_sequencer.sv
// Testbench for ccg_vector_sequencer: four instances with different
// vector counts and seeds, each fed by a selectable CUT stub
// (constant, x[3:0], or a random truth table).

module tb_ccg_vector_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  start_v = 4'h0;
   logic [3:0]  mode_v = 4'h0;
   logic [6:0]  x_v    [4];
   logic [3:0]  f_v    [4];
   logic        busy_v [4];
   logic        done_v [4];
   logic [15:0] sig_v  [4];
   logic [15:0] cnt_v  [4];

   int          fsel   [4] = '{0, 0, 0, 0};
   logic [3:0]  fconst [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
   logic [3:0]  ftab   [128];

   localparam int          NV [4]    = '{128, 127, 1, 2};
   localparam logic [6:0]  SEED [4]  = '{7'h01, 7'h00, 7'h01, 7'h01};
   localparam logic [15:0] MSEED [4] = '{16'h0000, 16'hACE1, 16'h0000, 16'h0000};

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         f_v[i] = fconst[i];
         if (fsel[i] == 1) f_v[i] = x_v[i][3:0];
         else if (fsel[i] == 2) f_v[i] = ftab[x_v[i]];
      end
   end

   ccg_vector_sequencer #(.N_VECT(128), .LFSR_SEED(7'h01), .MISR_SEED(16'h0000)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]), .x(x_v[0]), .f(f_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0]), .vec_count(cnt_v[0]));
   ccg_vector_sequencer #(.N_VECT(127), .LFSR_SEED(7'h00), .MISR_SEED(16'hACE1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]), .x(x_v[1]), .f(f_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1]), .vec_count(cnt_v[1]));
   ccg_vector_sequencer #(.N_VECT(1), .LFSR_SEED(7'h01), .MISR_SEED(16'h0000)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]), .x(x_v[2]), .f(f_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2]), .vec_count(cnt_v[2]));
   ccg_vector_sequencer #(.N_VECT(2), .LFSR_SEED(7'h01), .MISR_SEED(16'h0000)) u_d (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mode(mode_v[3]), .x(x_v[3]), .f(f_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .signature(sig_v[3]), .vec_count(cnt_v[3]));

   int n_chk  = 0;
   int n_pass = 0;
   logic [6:0] xs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: vector k is k mod 128 in counter mode; in LFSR mode the
   // stream steps through x^7+x^6+1 from the (zero-promoted) seed.
   function automatic logic [15:0] model_sig(input int n, input bit m, input logic [6:0] seed,
                                             input logic [15:0] ms, input int fs,
                                             input logic [3:0] fc, output logic [6:0] last_x);
      logic [6:0]  xv;
      logic [15:0] s;
      logic [3:0]  fv;
      logic        fb;
      s  = ms;
      xv = m ? ((seed == 7'h00) ? 7'h01 : seed) : 7'h00;
      for (int k = 0; k < n; k++) begin
         if (k > 0) xv = m ? {xv[5:0], xv[6] ^ xv[5]} : 7'(k % 128);
         fv = (fs == 1) ? xv[3:0] : (fs == 2) ? ftab[xv] : fc;
         fb = s[15] ^ s[13] ^ s[12] ^ s[10];
         s  = {s[14:0], fb} ^ {12'h000, fv};
      end
      last_x = xv;
      return s;
   endfunction

   task automatic run(input int i, input bit m, input bit poke, output int cyc, output logic d0);
      xs.delete();
      @(negedge clk);
      mode_v[i]  = m;
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      d0  = done_v[i];
      cyc = 0;
      while (busy_v[i] && cyc < 300) begin
         xs.push_back(x_v[i]);
         cyc++;
         if (poke) begin
            start_v[i] = (cyc % 17 == 5);
            mode_v[i]  = (cyc % 17 == 5) ? ~m : m;
         end
         @(negedge clk);
      end
      start_v[i] = 1'b0;
      mode_v[i]  = m;
   endtask

   typedef struct {
      int         dut;
      bit         m;
      int         fs;
      logic [3:0] fc;
      bit         poke;
      bit         use_model;
      logic [15:0] exp_sig;
      logic [6:0]  exp_x;
   } vec_t;

   vec_t tab[9];

   initial begin
      int          cyc;
      logic        d0;
      logic [6:0]  lx;
      logic [15:0] es;
      int          bad;
      bit          seen[128];
      vec_t        t;

      for (int k = 0; k < 128; k++) ftab[k] = 4'($urandom);

      tab[0] = '{2, 1'b0, 0, 4'h1, 1'b0, 1'b0, 16'h0001, 7'h00};
      tab[1] = '{3, 1'b0, 0, 4'h1, 1'b0, 1'b0, 16'h0003, 7'h01};
      tab[2] = '{3, 1'b0, 0, 4'h0, 1'b0, 1'b0, 16'h0000, 7'h01};
      tab[3] = '{3, 1'b1, 0, 4'hF, 1'b0, 1'b0, 16'h0011, 7'h02};
      tab[4] = '{2, 1'b1, 0, 4'hF, 1'b0, 1'b0, 16'h000F, 7'h01};
      tab[5] = '{0, 1'b0, 1, 4'h0, 1'b0, 1'b1, 16'h0000, 7'h00};
      tab[6] = '{1, 1'b1, 2, 4'h0, 1'b1, 1'b1, 16'h0000, 7'h00};
      tab[7] = '{0, 1'b1, 2, 4'h0, 1'b0, 1'b1, 16'h0000, 7'h00};
      tab[8] = '{0, 1'b0, 2, 4'h0, 1'b1, 1'b1, 16'h0000, 7'h00};

      // Reset, then idle with start low.
      repeat (3) @(negedge clk);
      chk("in_reset", {x_v[0], busy_v[0], done_v[0], sig_v[0], cnt_v[0]}, 32'h0);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("idle_c%0d", c), {x_v[0], busy_v[0], done_v[0], sig_v[0], cnt_v[0]}, 32'h0);
      end

      for (int v = 0; v < 9; v++) begin
         t = tab[v];
         fsel[t.dut]   = t.fs;
         fconst[t.dut] = t.fc;
         if (t.use_model) begin
            t.exp_sig = model_sig(NV[t.dut], t.m, SEED[t.dut], MSEED[t.dut], t.fs, t.fc, lx);
            t.exp_x   = lx;
         end
         run(t.dut, t.m, t.poke, cyc, d0);
         chk($sformatf("v%0d_busy_cycles", v), 32'(cyc), 32'(NV[t.dut]));
         chk($sformatf("v%0d_done_in_run", v), 32'(d0), 32'h0);
         chk($sformatf("v%0d_done", v), {busy_v[t.dut], done_v[t.dut]}, 32'h1);
         chk($sformatf("v%0d_sig", v), sig_v[t.dut], t.exp_sig);
         chk($sformatf("v%0d_cnt", v), cnt_v[t.dut], 32'(NV[t.dut]));
         chk($sformatf("v%0d_xhold", v), x_v[t.dut], t.exp_x);
         chk($sformatf("v%0d_first_x", v), (xs.size() > 0) ? xs[0] : 7'h7F, t.m ? 7'h01 : 7'h00);
         if (!t.m) begin
            bad = 0;
            foreach (xs[k]) if (xs[k] != 7'(k % 128)) bad++;
            chk($sformatf("v%0d_xwalk", v), 32'(bad), 32'h0);
         end else if (NV[t.dut] == 127) begin
            bad = 0;
            for (int k = 0; k < 128; k++) seen[k] = 1'b0;
            foreach (xs[k]) begin
               if (xs[k] == 7'h00 || seen[xs[k]]) bad++;
               seen[xs[k]] = 1'b1;
            end
            chk($sformatf("v%0d_lfsr_unique", v), 32'(bad), 32'h0);
            chk($sformatf("v%0d_lfsr_second", v), (xs.size() > 1) ? xs[1] : 7'h7F, 7'h02);
         end
      end

      // Randomized runs on the 128-vector instance.
      for (int r = 0; r < 3; r++) begin
         bit m;
         for (int k = 0; k < 128; k++) ftab[k] = 4'($urandom);
         m = 1'($urandom_range(0, 1));
         fsel[0] = 2;
         es = model_sig(128, m, 7'h01, 16'h0000, 2, 4'h0, lx);
         run(0, m, 1'b1, cyc, d0);
         chk($sformatf("rnd%0d_sig", r), sig_v[0], es);
         chk($sformatf("rnd%0d_x", r), x_v[0], lx);
      end

      // Mid-run asynchronous reset, then a clean rerun.
      fsel[0] = 2;
      @(negedge clk);
      mode_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (49) @(negedge clk);
      chk("pre_reset_busy", 32'(busy_v[0]), 32'h1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {x_v[0], busy_v[0], done_v[0], sig_v[0], cnt_v[0]}, 32'h0);
      @(negedge clk);
      chk("reset_held", {x_v[0], busy_v[0], done_v[0], sig_v[0], cnt_v[0]}, 32'h0);
      rst_n = 1'b1;
      es = model_sig(128, 1'b0, 7'h01, 16'h0000, 2, 4'h0, lx);
      run(0, 1'b0, 1'b0, cyc, d0);
      chk("rerun_cycles", 32'(cyc), 32'd128);
      chk("rerun_sig", sig_v[0], es);

      repeat (5) @(negedge clk);
      chk("done_hold", {done_v[0], busy_v[0], sig_v[0], cnt_v[0], x_v[0]},
          {1'b1, 1'b0, es, 16'd128, lx});

      // Restart directly from DONE in LFSR mode.
      es = model_sig(128, 1'b1, 7'h01, 16'h0000, 2, 4'h0, lx);
      run(0, 1'b1, 1'b0, cyc, d0);
      chk("restart_cycles", 32'(cyc), 32'd128);
      chk("restart_done_low", 32'(d0), 32'h0);
      chk("restart_sig", sig_v[0], es);
      chk("restart_x", x_v[0], lx);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
